// File: rtl/imem_refill_responder_pkg.sv
// Shared definitions for the instruction-memory refill responder:
// FSM encoding, width defaults and byte-address decode.
package imem_refill_responder_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   typedef struct packed {
      logic        ok;
      logic [63:0] idx;
   } addr_dec_t;

   // Word index relative to base, plus in-range flag (base <= addr < base + 4*depth).
   function automatic addr_dec_t addr_decode(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input logic [63:0] depth_words);
      addr_dec_t   d;
      logic [63:0] off;
      off   = addr - base;
      d.idx = off >> 2;
      d.ok  = (addr >= base) && (d.idx < depth_words);
      return d;
   endfunction

endpackage

// File: rtl/imem_store.sv
// Word-addressed instruction store: synchronous write, combinational read.
module imem_store #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int IDX_W       = 12,
   parameter     INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/imem_refill_responder.sv
// Memory-side responder for icache refills: programmable first/sequential
// latency, one registered mem_valid pulse per served request.
module imem_refill_responder
   import imem_refill_responder_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int                    DEPTH_WORDS   = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                    LINE_WORDS    = 4,
   parameter int                    FIRST_LATENCY = 4,
   parameter int                    BEAT_LATENCY  = 1,
   parameter                        INIT_FILE     = ""
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_req,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  addr_err
);

   localparam int MAX_LAT = (FIRST_LATENCY > BEAT_LATENCY) ? FIRST_LATENCY : BEAT_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int WA      = ADDR_WIDTH - 2;

   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(FIRST_LATENCY);
   localparam logic [CNT_W-1:0] CNT_BEAT  = CNT_W'(BEAT_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WA-1:0]    LINE_DIV  = WA'(LINE_WORDS);

   generate
      if (FIRST_LATENCY < 1 || BEAT_LATENCY < 1) begin : g_bad_latency
         $error("imem_refill_responder: FIRST_LATENCY and BEAT_LATENCY must be >= 1");
      end
   endgenerate

   logic [0:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_req_addr;
   logic [WA-1:0]         r_prev_word;
   logic                  r_mem_valid;
   logic [DATA_WIDTH-1:0] r_mem_data;
   logic                  r_busy;
   logic                  r_addr_err;

   addr_dec_t             w_rd_dec;
   addr_dec_t             w_wr_dec;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [WA-1:0]         w_req_word;
   logic [WA-1:0]         w_prev_next;
   logic                  w_seq;
   logic                  w_same_req;
   logic                  w_accept;
   logic                  w_redirect;
   logic                  w_respond;

   assign w_rd_dec = addr_decode(64'(r_req_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
   assign w_wr_dec = addr_decode(64'(wr_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));

   imem_store #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W),
      .INIT_FILE   (INIT_FILE)
   ) u_store (
      .clk       (clk),
      .i_wr_en   (wr_en && w_wr_dec.ok),
      .i_wr_idx  (w_wr_dec.idx[IDX_W-1:0]),
      .i_wr_data (wr_data),
      .i_rd_idx  (w_rd_dec.idx[IDX_W-1:0]),
      .o_rd_data (w_rd_data)
   );

   // Sequential beat: previous pulse was last cycle, next word, same line.
   assign w_req_word  = mem_addr[ADDR_WIDTH-1:2];
   assign w_prev_next = r_prev_word + WA'(1);
   assign w_seq       = r_mem_valid && (w_req_word == w_prev_next) &&
                        ((w_req_word / LINE_DIV) == (r_prev_word / LINE_DIV));
   assign w_same_req  = (mem_addr == r_req_addr);

   assign w_accept   = (r_state == ST_IDLE) && mem_req;
   assign w_redirect = (r_state == ST_WAIT) && mem_req && !w_same_req;
   assign w_respond  = (r_state == ST_WAIT) && mem_req && w_same_req && (r_cnt == CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_mem_valid <= 1'b0;
         r_mem_data  <= '0;
         r_busy      <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         r_mem_valid <= 1'b0;
         r_addr_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mem_req) begin
                  r_state <= ST_WAIT;
                  r_busy  <= 1'b1;
                  r_cnt   <= w_seq ? CNT_BEAT : CNT_FIRST;
               end
            end
            ST_WAIT: begin
               if (!mem_req) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (!w_same_req) begin
                  r_cnt <= CNT_FIRST;
               end else if (r_cnt == CNT_ONE) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_mem_valid <= 1'b1;
                  r_mem_data  <= w_rd_dec.ok ? w_rd_data : '0;
                  r_addr_err  <= !w_rd_dec.ok;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Address registers are only consumed when qualified by state or the pulse flag.
   always_ff @(posedge clk) begin
      if (w_accept || w_redirect) begin
         r_req_addr <= mem_addr;
      end
      if (w_respond) begin
         r_prev_word <= r_req_addr[ADDR_WIDTH-1:2];
      end
   end

   assign mem_valid = r_mem_valid;
   assign mem_data  = r_mem_data;
   assign busy      = r_busy;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: latency, line beats, abort,
// redirect, write hazard, out-of-range and asynchronous reset.
module tb_imem_refill_responder;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   logic [31:0] mem_data;
   logic        mem_valid;
   logic        busy;
   logic        addr_err;
   logic [31:0] s_mem_data;
   logic        s_mem_valid;
   logic        s_busy;
   logic        s_addr_err;

   int n_checks = 0;
   int n_errors = 0;

   imem_refill_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0),
      .LINE_WORDS(4), .FIRST_LATENCY(4), .BEAT_LATENCY(1), .INIT_FILE("")
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_valid(mem_valid), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .addr_err(addr_err)
   );

   imem_refill_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0),
      .LINE_WORDS(4), .FIRST_LATENCY(4), .BEAT_LATENCY(1), .INIT_FILE("")
   ) u_dut_small (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_data(s_mem_data), .mem_valid(s_mem_valid), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(s_busy), .addr_err(s_addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One active edge; returns at the following negedge to sample and drive.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      mem_req = 1'b0;
      repeat (n) tick();
   endtask

   int pe [5] = '{4, 6, 8, 10, 15};
   int nb;
   logic is_p;

   initial begin
      rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", mem_valid, 0);
      check("rst_data",  mem_data,  0);
      check("rst_busy",  busy,      0);
      check("rst_err",   addr_err,  0);
      rst_n = 1'b1;
      tick();

      wr(32'h0,   32'h0000_0013);
      wr(32'h20,  32'h1111_2222);
      for (int a = 32'h40; a <= 32'h50; a += 4) wr(a, 32'hA000_0000 | a);
      wr(32'h100, 32'hB000_0100);
      wr(32'h200, 32'hB000_0200);
      wr(32'h300, 32'hB000_0300);
      idle(2);

      // single read at first latency
      mem_req = 1'b1; mem_addr = 32'h0;
      for (int e = 0; e <= 4; e++) begin
         tick();
         check("t1_valid", mem_valid, (e == 4));
         check("t1_busy",  busy,      (e < 4));
      end
      check("t1_data", mem_data, 32'h0000_0013);
      check("t1_err",  addr_err, 0);
      mem_req = 1'b0;
      tick();
      check("t1_pulse_width", mem_valid, 0);
      idle(2);

      // line refill 0x40..0x4C then 0x50 in the next line
      mem_req = 1'b1; mem_addr = 32'h40; nb = 0;
      for (int e = 0; e <= 17; e++) begin
         tick();
         is_p = (nb < 5) && (e == pe[nb]);
         check("t2_valid", mem_valid, is_p);
         if (is_p) begin
            check("t2_data", mem_data, 32'hA000_0000 | mem_addr);
            nb++;
            if (nb < 5) mem_addr = mem_addr + 32'd4;
            else        mem_req  = 1'b0;
         end
      end
      check("t2_beats", nb, 5);
      idle(2);

      // abort then fresh request
      mem_req = 1'b1; mem_addr = 32'h100;
      for (int e = 0; e <= 10; e++) begin
         tick();
         check("t3_valid", mem_valid, (e == 9));
         check("t3_busy",  busy,      (e <= 1) || (e >= 5 && e <= 8));
         if (e == 9) check("t3_data", mem_data, 32'hB000_0200);
         if (e == 1) mem_req = 1'b0;
         if (e == 4) begin mem_req = 1'b1; mem_addr = 32'h200; end
         if (e == 9) mem_req = 1'b0;
      end
      idle(2);

      // redirect 0x100 -> 0x300
      mem_req = 1'b1; mem_addr = 32'h100;
      for (int e = 0; e <= 7; e++) begin
         tick();
         check("t4_valid", mem_valid, (e == 6));
         check("t4_busy",  busy,      (e < 6));
         if (e == 6) begin
            check("t4_data", mem_data, 32'hB000_0300);
            mem_req = 1'b0;
         end
         if (e == 1) mem_addr = 32'h300;
      end
      idle(2);

      // same-edge write returns old data, later re-read sees new data
      mem_req = 1'b1; mem_addr = 32'h20;
      for (int e = 0; e <= 4; e++) begin
         tick();
         if (e == 3) begin wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hDEAD_BEEF; end
      end
      wr_en = 1'b0;
      check("t5_valid_old", mem_valid, 1);
      check("t5_data_old",  mem_data,  32'h1111_2222);
      idle(2);
      mem_req = 1'b1; mem_addr = 32'h20;
      for (int e = 0; e <= 4; e++) tick();
      check("t5_valid_new", mem_valid, 1);
      check("t5_data_new",  mem_data,  32'hDEAD_BEEF);
      idle(2);

      // out of range on the 16-word instance
      mem_req = 1'b1; mem_addr = 32'h40;
      for (int e = 0; e <= 4; e++) begin
         tick();
         check("t6_s_valid", s_mem_valid, (e == 4));
         check("t6_s_err",   s_addr_err,  (e == 4));
      end
      check("t6_s_data",  s_mem_data, 0);
      check("t6_big_err", addr_err,   0);
      check("t6_big_data", mem_data,  32'hA000_0040);
      idle(2);

      // asynchronous reset mid-WAIT
      mem_req = 1'b1; mem_addr = 32'h100;
      tick();
      tick();
      check("t7_busy_before", busy, 1);
      rst_n = 1'b0; mem_req = 1'b0;
      #1;
      check("t7_rst_busy",  busy,      0);
      check("t7_rst_valid", mem_valid, 0);
      check("t7_rst_data",  mem_data,  0);
      check("t7_rst_err",   addr_err,  0);
      check("t7_rst_sdata", s_mem_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         check("t7_no_pulse", mem_valid, 0);
         check("t7_idle_busy", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
